// File: rtl/riscy_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single pipelined memory port.
// Round-robin on ties, lock while a request waits for its grant, and an
// in-order ID FIFO that steers each response back to its requester.
module riscy_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  // instruction side
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  // data side
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  // shared memory
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  src_e                  sel;
  src_e                  rr_q;        // source that wins the next tie
  src_e                  lock_src_q;
  logic                  lock_q;
  logic [ADDR_WIDTH-1:0] lock_addr_q;
  logic                  lock_we_q;
  logic [3:0]            lock_be_q;
  logic [DATA_WIDTH-1:0] lock_wdata_q;

  src_e                  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  err_q;

  logic                  any_req;
  logic                  pop;
  logic                  room;
  logic                  transfer;

  // Source selection: a held lock overrides the round-robin decision.
  always_comb begin
    sel     = rr_q;
    any_req = 1'b0;
    if (lock_q) begin
      sel     = lock_src_q;
      any_req = 1'b1;
    end else if (instr_req_i && data_req_i) begin
      sel     = rr_q;
      any_req = 1'b1;
    end else if (instr_req_i) begin
      sel     = SRC_INSTR;
      any_req = 1'b1;
    end else if (data_req_i) begin
      sel     = SRC_DATA;
      any_req = 1'b1;
    end
  end

  // Request gating, grants and response steering; reset forces all strobes low.
  always_comb begin
    pop            = rst_ni && mem_rvalid_i && (count_q != '0);
    room           = (count_q != MAX_CNT) || pop;
    mem_req_o      = rst_ni && any_req && room;
    transfer       = mem_req_o && mem_gnt_i;
    instr_gnt_o    = transfer && (sel == SRC_INSTR);
    data_gnt_o     = transfer && (sel == SRC_DATA);
    instr_rvalid_o = pop && (fifo_q[rd_ptr_q] == SRC_INSTR);
    data_rvalid_o  = pop && (fifo_q[rd_ptr_q] == SRC_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    err_o          = err_q;
  end

  // Memory payload: captured copy while locked, otherwise the selected port.
  always_comb begin
    mem_addr_o  = data_addr_i;
    mem_we_o    = data_we_i;
    mem_be_o    = data_be_i;
    mem_wdata_o = data_wdata_i;
    if (lock_q) begin
      mem_addr_o  = lock_addr_q;
      mem_we_o    = lock_we_q;
      mem_be_o    = lock_be_q;
      mem_wdata_o = lock_wdata_q;
    end else if (sel == SRC_INSTR) begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'b1111;
      mem_wdata_o = '0;
    end
  end

  // Lock capture on an ungranted request, release on transfer; round-robin update.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_src_q   <= SRC_INSTR;
      lock_addr_q  <= '0;
      lock_we_q    <= 1'b0;
      lock_be_q    <= '0;
      lock_wdata_q <= '0;
      rr_q         <= SRC_INSTR;
    end else begin
      if (mem_req_o && !mem_gnt_i) begin
        lock_q       <= 1'b1;
        lock_src_q   <= sel;
        lock_addr_q  <= mem_addr_o;
        lock_we_q    <= mem_we_o;
        lock_be_q    <= mem_be_o;
        lock_wdata_q <= mem_wdata_o;
      end else if (transfer) begin
        lock_q <= 1'b0;
      end
      if (transfer) begin
        rr_q <= (sel == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
      end
    end
  end

  // In-order ID FIFO with occupancy count and sticky spurious-response flag.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= SRC_INSTR;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (transfer) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (transfer && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !transfer) begin
        count_q <= count_q - 1'b1;
      end
      if (mem_rvalid_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// Scenario bench for riscy_mem_arbiter: expected responses are queued when a
// grant is expected and compared when the bench returns mem_rvalid_i.
module tb_riscy_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_we_i;
  logic [3:0]    data_be_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          err_o;

  typedef struct packed {
    logic        src;   // 0 = instruction, 1 = data
    logic [31:0] data;
  } resp_t;

  resp_t sb[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  always #5 clk = ~clk;

  riscy_mem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .err_o          (err_o)
  );

  // Instruction memory contents used by the instruction-stream scenario.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'h0000001B;
      32'h4:   rom = 32'h00000013;
      32'h8:   rom = 32'h00000033;
      default: rom = a ^ 32'h5A5A0000;
    endcase
  endfunction

  // One bus cycle: inputs change 1 time unit after the rising edge, outputs
  // are then sampled at the falling edge by the caller.
  task automatic apply(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic gnt, input logic rv);
    @(posedge clk);
    #1;
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = daddr;
    data_wdata_i = dwdata;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = (rv && sb.size() != 0) ? sb[0].data : 32'hBAD0BAD0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    rst_ni       = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_ni       = 1'b0;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h2000;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req/ig/dg/irv/drv/err=%b required 000000",
               {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o});
    end
    @(posedge clk);
    #1;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    rst_ni       = 1'b1;
  endtask

  task automatic test_instr_stream();
    resp_t       exp;
    logic [31:0] got;
    for (int c = 0; c < 4; c++) begin
      logic [31:0] a;
      a = 32'(c * 4);
      apply(c < 3, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, c > 0);
      if (c > 0) begin
        exp = sb.pop_front();
        got = instr_rdata_o;
        tests_run++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~exp.src, exp.src} || got !== exp.data) begin
          tests_failed++;
          $display("FAIL istream_resp%0d: got rv=%b%b rdata=%h required rv=%b%b rdata=%h", c,
                   instr_rvalid_o, data_rvalid_o, got, ~exp.src, exp.src, exp.data);
        end
      end
      if (c < 3) begin
        tests_run++;
        if ({instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 1'b0, 4'hF, a}) begin
          tests_failed++;
          $display("FAIL istream_grant%0d: got ig=%b dg=%b we=%b be=%h addr=%h required 1 0 0 f %h", c,
                   instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o, mem_addr_o, a);
        end
        sb.push_back('{src: 1'b0, data: rom(a)});
      end
    end
  endtask

  task automatic test_tie();
    resp_t       exp;
    logic [31:0] got;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      logic        s;
      logic [31:0] ia, da;
      s  = c[0];
      ia = 32'h100 + 32'(c * 4);
      da = 32'h2000 + 32'(c * 4);
      apply(c < 4, ia, c < 4, 1'b1, 4'hF, da, 32'hDEADBEEF, 1'b1, c > 0);
      if (c > 0) begin
        exp = sb.pop_front();
        got = exp.src ? data_rdata_o : instr_rdata_o;
        tests_run++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~exp.src, exp.src} || got !== exp.data) begin
          tests_failed++;
          $display("FAIL tie_resp%0d: got rv=%b%b rdata=%h required rv=%b%b rdata=%h", c,
                   instr_rvalid_o, data_rvalid_o, got, ~exp.src, exp.src, exp.data);
        end
      end
      if (c < 4) begin
        tests_run++;
        if ({instr_gnt_o, data_gnt_o} !== {~s, s} || mem_addr_o !== (s ? da : ia) || mem_we_o !== s ||
            (s && (mem_wdata_o !== 32'hDEADBEEF || mem_be_o !== 4'hF))) begin
          tests_failed++;
          $display("FAIL tie_grant%0d: got ig/dg=%b%b addr=%h we=%b wdata=%h be=%h required %b%b addr=%h we=%b",
                   c, instr_gnt_o, data_gnt_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o,
                   ~s, s, s ? da : ia, s);
        end
        sb.push_back('{src: s, data: 32'hA5A50000 + 32'(c)});
      end
    end
  endtask

  task automatic test_lock();
    resp_t       exp;
    logic [31:0] got;
    // Previous scenario ended on a data grant, so instruction would win a tie.
    for (int c = 0; c < 6; c++) begin
      logic [1:0]  eg;
      logic [31:0] ea;
      eg = (c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      ea = (c <= 3) ? 32'h2004 : 32'h40;
      apply(c >= 1 && c <= 4, 32'h40, c <= 3, 1'b0, 4'hF, 32'h2004, 32'h0, c >= 3, c >= 4);
      if (c >= 4) begin
        exp = sb.pop_front();
        got = exp.src ? data_rdata_o : instr_rdata_o;
        tests_run++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~exp.src, exp.src} || got !== exp.data) begin
          tests_failed++;
          $display("FAIL lock_resp%0d: got rv=%b%b rdata=%h required rv=%b%b rdata=%h", c,
                   instr_rvalid_o, data_rvalid_o, got, ~exp.src, exp.src, exp.data);
        end
      end
      tests_run++;
      if ({instr_gnt_o, data_gnt_o} !== eg || (c <= 4 && (mem_req_o !== 1'b1 || mem_addr_o !== ea))) begin
        tests_failed++;
        $display("FAIL lock_cycle%0d: got req=%b ig/dg=%b%b addr=%h required req=1 %b addr=%h", c,
                 mem_req_o, instr_gnt_o, data_gnt_o, mem_addr_o, eg, ea);
      end
      if (eg != 2'b00) sb.push_back('{src: eg[0], data: 32'h10C00000 + 32'(c)});
    end
  endtask

  task automatic test_outstanding();
    resp_t       exp;
    logic [31:0] got;
    int          k = 0;
    // Phase A: instruction-only, responses withheld until the limit is hit.
    for (int c = 0; c < 4; c++) begin
      logic        eg;
      logic [31:0] a;
      a  = 32'h200 + 32'(k * 4);
      eg = (c != 2);
      apply(1'b1, a, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, c == 3);
      if (c == 3) begin
        exp = sb.pop_front();
        got = instr_rdata_o;
        tests_run++;
        if ({instr_rvalid_o, data_rvalid_o} !== {~exp.src, exp.src} || got !== exp.data) begin
          tests_failed++;
          $display("FAIL limit_resp: got rv=%b%b rdata=%h required rv=%b%b rdata=%h",
                   instr_rvalid_o, data_rvalid_o, got, ~exp.src, exp.src, exp.data);
        end
      end
      tests_run++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o} !== {eg, eg, 1'b0}) begin
        tests_failed++;
        $display("FAIL limit_cycle%0d: got req/ig/dg=%b%b%b required %b%b0", c,
                 mem_req_o, instr_gnt_o, data_gnt_o, eg, eg);
      end
      if (eg) begin
        sb.push_back('{src: 1'b0, data: rom(a)});
        k++;
      end
    end
    // Phase B: both ports, push and pop every cycle across FIFO wrap-around.
    for (int i = 0; i < 12; i++) begin
      logic        s, busy;
      logic [31:0] ia, da;
      busy = (i < 10);
      s    = ~i[0];
      ia   = 32'h300 + 32'(i * 4);
      da   = 32'h4000 + 32'(i * 4);
      apply(busy, ia, busy, 1'b0, 4'h3, da, 32'h0, 1'b1, 1'b1);
      exp = sb.pop_front();
      got = exp.src ? data_rdata_o : instr_rdata_o;
      tests_run++;
      if ({instr_rvalid_o, data_rvalid_o} !== {~exp.src, exp.src} || got !== exp.data) begin
        tests_failed++;
        $display("FAIL wrap_resp%0d: got rv=%b%b rdata=%h required rv=%b%b rdata=%h", i,
                 instr_rvalid_o, data_rvalid_o, got, ~exp.src, exp.src, exp.data);
      end
      tests_run++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o} !== {busy, busy & ~s, busy & s} ||
          (busy && (mem_addr_o !== (s ? da : ia) || mem_be_o !== (s ? 4'h3 : 4'hF)))) begin
        tests_failed++;
        $display("FAIL wrap_grant%0d: got req/ig/dg=%b%b%b addr=%h be=%h required %b%b%b addr=%h",
                 i, mem_req_o, instr_gnt_o, data_gnt_o, mem_addr_o, mem_be_o,
                 busy, busy & ~s, busy & s, s ? da : ia);
      end
      if (busy) sb.push_back('{src: s, data: 32'h77000000 + 32'(i)});
    end
  endtask

  task automatic test_spurious();
    resp_t       exp;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL spurious_rvalid: got %b%b required 00", instr_rvalid_o, data_rvalid_o);
    end
    apply(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({err_o, instr_gnt_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL spurious_err: got err=%b ig=%b required err=1 ig=1", err_o, instr_gnt_o);
    end
    sb.push_back('{src: 1'b0, data: rom(32'h500)});
    apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    exp = sb.pop_front();
    tests_run++;
    if ({err_o, instr_rvalid_o, data_rvalid_o} !== 3'b110 || instr_rdata_o !== exp.data) begin
      tests_failed++;
      $display("FAIL spurious_sticky: got err/irv/drv=%b%b%b rdata=%h required 110 rdata=%h",
               err_o, instr_rvalid_o, data_rvalid_o, instr_rdata_o, exp.data);
    end
    do_reset();
    @(negedge clk);
    tests_run++;
    if (err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_clear: got err=%b required 0", err_o);
    end
  endtask

  task automatic test_reset_midflight();
    resp_t       exp;
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 32'h600, 1'b1, 1'b0, 4'hF, 32'h6000, 32'h0, 1'b1, 1'b0);
      tests_run++;
      if ({instr_gnt_o, data_gnt_o} !== {c == 0, c == 1}) begin
        tests_failed++;
        $display("FAIL midflight_fill%0d: got ig/dg=%b%b required %b%b", c,
                 instr_gnt_o, data_gnt_o, c == 0, c == 1);
      end
    end
    // Two responses outstanding; reset lands mid-cycle with everything active.
    @(posedge clk);
    #1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h12345678;
    #2;
    rst_ni = 1'b0;
    sb.delete();
    @(negedge clk);
    tests_run++;
    if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL midflight_outputs: got req/ig/dg/irv/drv/err=%b required 000000",
               {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o});
    end
    @(posedge clk);
    #1;
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    mem_rvalid_i = 1'b0;
    rst_ni       = 1'b1;
    apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midflight_discard: got rv=%b%b required 00", instr_rvalid_o, data_rvalid_o);
    end
    apply(1'b1, 32'h700, 1'b1, 1'b0, 4'hF, 32'h7000, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({err_o, instr_gnt_o, data_gnt_o} !== 3'b110 || mem_addr_o !== 32'h700) begin
      tests_failed++;
      $display("FAIL midflight_tie: got err/ig/dg=%b%b%b addr=%h required 110 addr=00000700",
               err_o, instr_gnt_o, data_gnt_o, mem_addr_o);
    end
    sb.push_back('{src: 1'b0, data: rom(32'h700)});
    apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    exp = sb.pop_front();
    tests_run++;
    if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== exp.data) begin
      tests_failed++;
      $display("FAIL midflight_resp: got rv=%b%b rdata=%h required 10 rdata=%h",
               instr_rvalid_o, data_rvalid_o, instr_rdata_o, exp.data);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    test_reset();
    test_instr_stream();
    test_tie();
    test_lock();
    test_outstanding();
    test_spurious();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
